// File: rtl/main_mem_responder.sv
// Main-memory responder for the cache_2wsa memory port.
// Edge-triggered line requests, fixed latency, 4-beat bursts over an internal byte array.
module main_mem_responder #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_ADDR_BITS = 10,
  parameter int LATENCY       = 4,
  parameter int BURST_LEN     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_mem,
  input  logic                  rd_mem,
  input  logic                  wr_mem,
  inout  wire  [DATA_WIDTH-1:0] data_mem,
  output logic                  ready_mem,
  output logic                  valid_mem
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam int         LW        = MEM_ADDR_BITS - 2;
  localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_BITS];

  logic [1:0]            state_q, state_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  dir_q, dir_d;
  logic [LW-1:0]         line_q, line_d;
  logic [3:0]            wait_q, wait_d;
  logic [1:0]            beat_q, beat_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_edge, wr_edge;
  logic                  mem_we;

  logic unused_addr;
  assign unused_addr = ^{addr_mem[ADDR_WIDTH-1:MEM_ADDR_BITS],
                         addr_mem[1:0]};

  assign data_mem  = oe_q ? dout_q : 'z;
  assign ready_mem = ready_q;
  assign valid_mem = valid_q;

  // Next-state: edge-detect requests in IDLE, count latency, step beats.
  always_comb begin
    rd_d    = rd_mem;
    wr_d    = wr_mem;
    rd_edge = rd_mem & ~rd_q;
    wr_edge = wr_mem & ~wr_q;
    state_d = state_q;
    dir_d   = dir_q;
    line_d  = line_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_edge | wr_edge) begin
          state_d = S_WAIT;
          dir_d   = wr_edge;
          line_d  = addr_mem[MEM_ADDR_BITS-1:2];
          wait_d  = 4'd0;
          beat_d  = 2'd0;
        end
      end
      S_WAIT: begin
        if (wait_q == LAST_WAIT) state_d = S_BURST;
        else wait_d = wait_q + 4'd1;
      end
      S_BURST: begin
        mem_we = dir_q;
        if (beat_q == LAST_BEAT) state_d = S_IDLE;
        else beat_d = beat_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_BURST);
    oe_d    = valid_d & ~dir_d;
    dout_d  = mem[{line_d, beat_d}];
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dir_q   <= 1'b0;
      line_q  <= '0;
      wait_q  <= 4'd0;
      beat_q  <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      line_q  <= line_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  // Byte array: capture write beats; reset suppresses the beat in flight.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[{line_q, beat_q}] <= data_mem;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized self-checking bench for main_mem_responder.
// Timeline model keyed on accept cycle plus a byte-array reference.
module tb_main_mem_responder;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_mem = '0;
  logic        rd_mem = 1'b0;
  logic        wr_mem = 1'b0;
  wire  [7:0]  data_mem;
  logic        ready_mem, valid_mem;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dout = '0;

  logic [15:0] addr1 = '0;
  logic        rd1 = 1'b0;
  logic        wr1 = 1'b0;
  wire  [7:0]  data1;
  logic        ready1, valid1;
  logic        tb1_oe = 1'b0;
  logic [7:0]  tb1_dout = '0;

  assign data_mem = tb_oe ? tb_dout : 'z;
  assign data1    = tb1_oe ? tb1_dout : 'z;

  main_mem_responder #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .addr_mem(addr_mem),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .data_mem(data_mem),
    .ready_mem(ready_mem), .valid_mem(valid_mem)
  );

  main_mem_responder #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .addr_mem(addr1),
    .rd_mem(rd1), .wr_mem(wr1), .data_mem(data1),
    .ready_mem(ready1), .valid_mem(valid1)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;

  logic [7:0] mm [0:1023];
  bit         known [0:1023];
  bit         busy = 1'b0;
  int         acc = 0;
  bit         m_wr = 1'b0;
  logic [9:0] m_base = '0;
  logic [7:0] wq [4];
  bit         prd = 1'b0;
  bit         pwr = 1'b0;
  logic [7:0] seen [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic bit is_rel(input logic [7:0] v);
    return $isunknown(v) || (v == 8'h00);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cycle(input bit rd, input bit wr,
                           input logic [15:0] a,
                           input logic [31:0] wd, input bit rst);
    int k;
    bit inb, idle_now;
    logic [9:0] idx;
    k = cyc - acc;
    inb = busy && (k >= LAT + 1) && (k <= LAT + 4);
    idle_now = !busy || (k >= LAT + 5);
    idx = m_base + 10'(k - LAT - 1);
    rd_mem = rd;
    wr_mem = wr;
    addr_mem = a;
    reset = rst;
    tb_oe = inb && m_wr;
    tb_dout = (inb && m_wr) ? wq[k - LAT - 1] : 8'h00;
    #1;
    check("ready", 32'(ready_mem), 32'(!(busy && k >= 1 && k <= LAT + 4)));
    check("valid", 32'(valid_mem), 32'(inb));
    if (valid_mem) n_valid++;
    if (inb && !m_wr) begin
      if (known[idx]) check("rdata", 32'(data_mem), 32'(mm[idx]));
      seen.push_back(data_mem);
    end else if (inb && m_wr) begin
      check("wbus", 32'(data_mem), 32'(tb_dout));
    end else begin
      check("relz", 32'(is_rel(data_mem)), 32'd1);
    end
    if (rst) begin
      busy = 1'b0;
      prd = 1'b0;
      pwr = 1'b0;
    end else begin
      if (inb && m_wr) begin
        mm[idx] = tb_dout;
        known[idx] = 1'b1;
      end
      if (idle_now && ((rd && !prd) || (wr && !pwr))) begin
        busy = 1'b1;
        acc = cyc;
        m_wr = wr && !pwr;
        m_base = {a[9:2], 2'b00};
        for (int b = 0; b < 4; b++) wq[b] = wd[8*b +: 8];
      end
      prd = rd;
      pwr = wr;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic hold(input bit rd, input bit wr, input int n);
    for (int i = 0; i < n; i++) run_cycle(rd, wr, 16'h0, 32'h0, 1'b0);
  endtask

  task automatic expect_beats(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (seen.size() == 4) got = {seen[3], seen[2], seen[1], seen[0]};
    check(tag, got, exp);
  endtask

  initial begin
    int nv0;
    bit r, w;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    idle(2);

    for (int i = 0; i < 256; i++) begin
      run_cycle(1'b0, 1'b1, {6'($urandom), 8'(i), 2'($urandom)},
                $urandom, 1'b0);
      idle(8);
    end

    run_cycle(1'b0, 1'b1, 16'h008B, 32'h44332211, 1'b0);
    idle(9);
    seen.delete();
    run_cycle(1'b1, 1'b0, 16'h0088, 32'h0, 1'b0);
    idle(9);
    expect_beats("wr_rd", 32'h44332211);

    seen.delete();
    run_cycle(1'b1, 1'b0, 16'hC08B, 32'h0, 1'b0);
    idle(9);
    expect_beats("alias", 32'h44332211);

    nv0 = n_valid;
    hold(1'b1, 1'b0, 20);
    check("hold_one", 32'(n_valid - nv0), 32'd4);
    idle(1);
    hold(1'b1, 1'b0, 12);
    check("hold_two", 32'(n_valid - nv0), 32'd8);
    idle(2);

    nv0 = n_valid;
    run_cycle(1'b1, 1'b0, 16'h0088, 32'h0, 1'b0);
    hold(1'b1, 1'b0, LAT + 1);
    hold(1'b1, 1'b1, 15);
    idle(3);
    check("wr_in_burst", 32'(n_valid - nv0), 32'd4);

    run_cycle(1'b1, 1'b1, 16'h0100, 32'hDDCCBBAA, 1'b0);
    idle(9);
    seen.delete();
    run_cycle(1'b1, 1'b0, 16'h0100, 32'h0, 1'b0);
    idle(9);
    expect_beats("collide", 32'hDDCCBBAA);

    run_cycle(1'b0, 1'b1, 16'h0200, 32'h0, 1'b0);
    idle(9);
    run_cycle(1'b0, 1'b1, 16'h0200, 32'h04030201, 1'b0);
    idle(LAT + 2);
    run_cycle(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    idle(2);
    seen.delete();
    run_cycle(1'b1, 1'b0, 16'h0200, 32'h0, 1'b0);
    idle(LAT + 2);
    run_cycle(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    idle(2);
    seen.delete();
    run_cycle(1'b1, 1'b0, 16'h0200, 32'h0, 1'b0);
    idle(9);
    expect_beats("rst_mid", 32'h00000201);

    nv0 = n_valid;
    run_cycle(1'b1, 1'b0, 16'h0, 32'h0, 1'b1);
    run_cycle(1'b1, 1'b0, 16'h0, 32'h0, 1'b1);
    hold(1'b1, 1'b0, 12);
    check("hold_rst", 32'(n_valid - nv0), 32'd4);
    idle(2);

    r = 1'b0;
    w = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) r = ~r;
      if ($urandom_range(0, 6) == 0) w = ~w;
      run_cycle(r, w, 16'($urandom), $urandom,
                $urandom_range(0, 399) == 0);
    end
    idle(12);

    addr1 = 16'h0044;
    wr1 = 1'b1;
    tick();
    wr1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tb1_oe = (c >= 2 && c <= 5);
      tb1_dout = tb1_oe ? 8'(8'h10 + c) : 8'h00;
      #1;
      check("l1_wr_ready", 32'(ready1), 32'(c >= 6));
      check("l1_wr_valid", 32'(valid1), 32'(c >= 2 && c <= 5));
      tick();
    end
    tb1_oe = 1'b0;
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check("l1_rd_ready", 32'(ready1), 32'(c >= 6));
      check("l1_rd_valid", 32'(valid1), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) check("l1_rdata", 32'(data1), 32'(8'h10 + c));
      else check("l1_relz", 32'(is_rel(data1)), 32'd1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
